// File: rtl/dec_syndrome.sv
// RS decoder syndrome front end: per-lane Horner update of all syndromes per beat.
// Optional DEC_SYN_ERR_FLAG_EN adds a registered any-nonzero-syndrome flag.
module dec_syndrome #(
    parameter int          EGF_ORDER   = 8,
    parameter int unsigned EGF_PRI_POL = 'h11D,
    parameter int          RS_MES_LEN  = 239,
    parameter int          RS_PAR_LEN  = 16,
    parameter int          RS_FCR      = 0,
    parameter int          DEC_SYM_NUM = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DEC_SYM_NUM*EGF_ORDER-1:0]  in_data,
    output logic                              syn_valid,
    input  logic                              syn_ready,
    output logic [RS_PAR_LEN*EGF_ORDER-1:0]   syn_data
`ifdef DEC_SYN_ERR_FLAG_EN
    ,
    output logic                              syn_err
`endif
);

    localparam int RS_COD_LEN = RS_MES_LEN + RS_PAR_LEN;
    localparam int BEATS      = (RS_COD_LEN + DEC_SYM_NUM - 1) / DEC_SYM_NUM;
    localparam int FIR_NUM    = RS_COD_LEN % DEC_SYM_NUM;
    localparam int CNT_W      = $clog2(BEATS + 1);

    localparam logic [EGF_ORDER-1:0] POLY    = EGF_ORDER'(EGF_PRI_POL);
    localparam logic [CNT_W-1:0]     CNT_LAS = CNT_W'(BEATS - 2);

    typedef logic [EGF_ORDER-1:0] sym_t;
    typedef logic [RS_PAR_LEN-1:0][EGF_ORDER-1:0] syn_t;
    typedef enum logic [1:0] {SYN_FIR, SYN_NOR, SYN_LAS} phase_t;

    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t p;
        sym_t t;
        p = '0;
        t = a;
        for (int i = 0; i < EGF_ORDER; i++) begin
            if (b[i]) p = p ^ t;
            t = t[EGF_ORDER-1] ? ((t << 1) ^ POLY) : (t << 1);
        end
        return p;
    endfunction

    function automatic syn_t alpha_tab();
        syn_t r;
        for (int j = 0; j < RS_PAR_LEN; j++) begin
            r[j] = sym_t'(1);
            for (int k = 0; k < RS_FCR + j; k++)
                r[j] = gf_mul(r[j], sym_t'(2));
        end
        return r;
    endfunction

    function automatic logic [DEC_SYM_NUM-1:0] fir_mask();
        logic [DEC_SYM_NUM-1:0] m;
        for (int l = 0; l < DEC_SYM_NUM; l++)
            m[l] = (FIR_NUM == 0) || (l < FIR_NUM);
        return m;
    endfunction

    localparam syn_t                   ALPHA    = alpha_tab();
    localparam logic [DEC_SYM_NUM-1:0] FIR_MASK = fir_mask();

    phase_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    syn_t             acc_q, acc_d, acc_upd;
    syn_t             syn_data_q, syn_data_d;
    logic             syn_valid_q, syn_valid_d;
    logic             accept, last;

    assign in_ready  = !syn_valid_q || syn_ready;
    assign accept    = in_valid && in_ready;
    assign last      = (state_q == SYN_LAS) || ((state_q == SYN_FIR) && (BEATS == 1));
    assign syn_valid = syn_valid_q;
    assign syn_data  = syn_data_q;

    // First beat restarts from zero so a stale accumulator never leaks in.
    always_comb begin
        acc_upd = (state_q == SYN_FIR) ? '0 : acc_q;
        for (int l = DEC_SYM_NUM - 1; l >= 0; l--) begin
            if ((state_q != SYN_FIR) || FIR_MASK[l]) begin
                for (int j = 0; j < RS_PAR_LEN; j++)
                    acc_upd[j] = gf_mul(acc_upd[j], ALPHA[j])
                               ^ in_data[l*EGF_ORDER +: EGF_ORDER];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        syn_data_d  = syn_data_q;
        syn_valid_d = syn_valid_q && !syn_ready;
        if (accept) begin
            acc_d = acc_upd;
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                SYN_FIR: state_d = (BEATS == 1) ? SYN_FIR :
                                   (BEATS == 2) ? SYN_LAS : SYN_NOR;
                SYN_NOR: if (cnt_q == CNT_LAS) state_d = SYN_LAS;
                SYN_LAS: state_d = SYN_FIR;
                default: state_d = SYN_FIR;
            endcase
            if (last) begin
                syn_data_d  = acc_upd;
                syn_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SYN_FIR;
            cnt_q       <= '0;
            acc_q       <= '0;
            syn_data_q  <= '0;
            syn_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            syn_data_q  <= syn_data_d;
            syn_valid_q <= syn_valid_d;
        end
    end

`ifdef DEC_SYN_ERR_FLAG_EN
    logic syn_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            syn_err_q <= 1'b0;
        else if (accept && last)
            syn_err_q <= |acc_upd;
    end

    assign syn_err = syn_err_q;
`endif

endmodule

// File: tb/tb_dec_syndrome.sv
// Bench for dec_syndrome: directed codewords checked against a
// log/exp-table evaluation of r(alpha^j) and an in-bench RS encoder.
module tb_dec_syndrome;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         syn_valid;
    logic         syn_ready;
    logic [127:0] syn_data;
`ifdef DEC_SYN_ERR_FLAG_EN
    logic         syn_err;
`endif

    dec_syndrome dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .syn_valid (syn_valid),
        .syn_ready (syn_ready),
        .syn_data  (syn_data)
`ifdef DEC_SYN_ERR_FLAG_EN
        ,
        .syn_err   (syn_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_t [0:254];
    int log_t [0:255];
    logic [7:0] cw [0:254];
    logic [127:0] exp_q [$];
    bit lat_pend = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    // S_j = sum_i r_i * alpha^(i*j), evaluated directly per coefficient
    function automatic logic [127:0] model_syn();
        logic [127:0] r;
        int s;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            s = 0;
            for (int i = 0; i < 255; i++)
                if (cw[i] != 0)
                    s = s ^ exp_t[(log_t[int'(cw[i])] + i * j) % 255];
            r[j*8 +: 8] = 8'(s);
        end
        return r;
    endfunction

    task automatic clear_cw();
        for (int i = 0; i < 255; i++) cw[i] = 8'h00;
    endtask

    task automatic make_valid(input int seed);
        int g [0:16];
        int p [0:15];
        int fb;
        for (int k = 0; k < 17; k++) g[k] = 0;
        g[0] = 1;
        for (int j = 0; j < 16; j++) begin
            for (int k = j + 1; k >= 1; k--)
                g[k] = g[k-1] ^ gmul(g[k], exp_t[j]);
            g[0] = gmul(g[0], exp_t[j]);
        end
        for (int i = 16; i < 255; i++)
            cw[i] = 8'((i * 37 + seed * 101 + $urandom) & 255);
        for (int k = 0; k < 16; k++) p[k] = 0;
        for (int d = 254; d >= 16; d--) begin
            fb = int'(cw[d]) ^ p[15];
            for (int k = 15; k >= 1; k--) p[k] = p[k-1] ^ gmul(fb, g[k]);
            p[0] = gmul(fb, g[0]);
        end
        for (int k = 0; k < 16; k++) cw[k] = 8'(p[k]);
    endtask

    task automatic send_beat(input logic [31:0] d, output bit ok);
        in_data  = d;
        in_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 'x;
        if (!ok) chk(0, "beat_accept_timeout", 0, 1);
    endtask

    task automatic send_cw(input int nbeats, input logic [7:0] garbage);
        logic [31:0] d;
        logic [127:0] e;
        bit ok;
        int deg;
        e = model_syn();
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 4; l++) begin
                deg = (63 - b) * 4 + l;
                d[l*8 +: 8] = (deg <= 254) ? cw[deg] : garbage;
            end
            send_beat(d, ok);
            if (!ok) return;
            if (b == 63) begin
                exp_q.push_back(e);
                lat_pend = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (lat_pend) begin
                chk(syn_valid === 1'b1, "latency_valid", 128'(syn_valid), 1);
                lat_pend = 0;
            end
            if (syn_valid) begin
                if (exp_q.size() == 0) begin
                    chk(0, "spurious_syn_valid", syn_data, 0);
                end else begin
                    chk(syn_data === exp_q[0], "syn_data", syn_data, exp_q[0]);
`ifdef DEC_SYN_ERR_FLAG_EN
                    chk(syn_err === (|exp_q[0]), "syn_err", 128'(syn_err),
                        128'(|exp_q[0]));
`endif
                    if (syn_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int x;
        logic [127:0] m;
        logic [127:0] all5a;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        log_t[0] = 0;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        syn_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(syn_valid === 1'b0, "reset_syn_valid", 128'(syn_valid), 0);
        chk(in_ready === 1'b1, "reset_in_ready", 128'(in_ready), 1);
        chk(syn_data === '0, "reset_syn_data", syn_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        clear_cw();
        m = model_syn();
        chk(m === '0, "model_zero", m, 0);
        send_cw(64, 8'h00);

        make_valid(1);
        m = model_syn();
        chk(m === '0, "model_valid_cw", m, 0);
        send_cw(64, 8'h00);
        idle(3);

        clear_cw();
        cw[254] = 8'h01;
        m = model_syn();
        chk(m[7:0] === 8'h01, "model_r254_s0", 128'(m[7:0]), 128'h01);
        chk(m[15:8] === 8'h8E, "model_r254_s1", 128'(m[15:8]), 128'h8E);
        chk(m[23:16] === 8'h47, "model_r254_s2", 128'(m[23:16]), 128'h47);
        send_cw(64, 8'h00);

        clear_cw();
        cw[0] = 8'h5A;
        m = model_syn();
        all5a = {16{8'h5A}};
        chk(m === all5a, "model_r0_5a", m, all5a);
        send_cw(64, 8'h00);
        idle(3);

        make_valid(2);
        send_cw(64, 8'hFF);
        idle(3);

        syn_ready = 1'b0;
        make_valid(3);
        send_cw(64, 8'h00);
        clear_cw();
        cw[100] = 8'h33;
        cw[3] = 8'hC1;
        fork
            send_cw(64, 8'h00);
            begin
                repeat (8) begin
                    @(negedge clk);
                    chk(in_ready === 1'b0, "bp_in_ready", 128'(in_ready), 0);
                end
                @(posedge clk);
                #1 syn_ready = 1'b1;
            end
        join
        idle(3);

        make_valid(4);
        send_cw(30, 8'h00);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        chk(syn_valid === 1'b0, "midreset_syn_valid", 128'(syn_valid), 0);
        chk(in_ready === 1'b1, "midreset_in_ready", 128'(in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        make_valid(5);
        send_cw(64, 8'h00);
        idle(5);

        chk(exp_q.size() == 0, "results_drained", 128'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
